// File: rtl/pixel_scan_tracer.sv
// Frame scheduler around a stallable ray/box pipeline: rasters every pixel, issues one
// test per box, and folds the returning hit stream into the closest hit per pixel.
module pixel_scan_tracer #(
   parameter int H_RES     = 800,
   parameter int V_RES     = 600,
   parameter int NUM_BOXES = 4,
   parameter int PIPE_LAT  = 24,
   parameter int DIST_W    = 49,
   localparam int BW       = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1
) (
   input  logic              sysclk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              frame_done,
   output logic              pipe_stall,
   output logic              pipe_issue,
   output logic [9:0]        pipe_pixel_x,
   output logic [9:0]        pipe_pixel_y,
   output logic [BW-1:0]     pipe_box_idx,
   input  logic              pipe_hit,
   input  logic [DIST_W-1:0] pipe_dist,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic [9:0]        pix_x,
   output logic [9:0]        pix_y,
   output logic              pix_hit,
   output logic [BW-1:0]     pix_box,
   output logic [DIST_W-1:0] pix_dist
);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

   typedef struct packed {
      logic          valid;
      logic          first;
      logic          last;
      logic [9:0]    x;
      logic [9:0]    y;
      logic [BW-1:0] box;
   } tag_t;

   state_t state, state_next;

   logic [9:0]    x_cnt, y_cnt;
   logic [BW-1:0] box_cnt;
   logic          stall, box_wrap, x_wrap, scan_end;
   logic          accept, last_pix_out, fold_en;

   tag_t tag_pipe [PIPE_LAT];
   tag_t tag_in, tail;

   logic              acc_hit, fold_hit;
   logic [DIST_W-1:0] acc_dist, fold_dist;
   logic [BW-1:0]     acc_box, fold_box;

   assign stall        = pix_valid && !pix_ready;
   assign pipe_stall   = stall;
   assign box_wrap     = (box_cnt == BW'(NUM_BOXES - 1));
   assign x_wrap       = (x_cnt == 10'(H_RES - 1));
   assign scan_end     = box_wrap && x_wrap && (y_cnt == 10'(V_RES - 1));
   assign accept       = pix_valid && pix_ready;
   assign last_pix_out = (pix_x == 10'(H_RES - 1)) && (pix_y == 10'(V_RES - 1));

   assign pipe_pixel_x = x_cnt;
   assign pipe_pixel_y = y_cnt;
   assign pipe_box_idx = box_cnt;

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = SCAN;
         SCAN:    if (!stall && scan_end) state_next = DRAIN;
         DRAIN:   if (accept && last_pix_out) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy       = (state != IDLE);
      pipe_issue = (state == SCAN) && !stall;
      frame_done = (state == DRAIN) && accept && last_pix_out;
   end

   // Raster counters: box is the fastest index, then x, then y.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         x_cnt   <= '0;
         y_cnt   <= '0;
         box_cnt <= '0;
      end else if (state == IDLE && start) begin
         x_cnt   <= '0;
         y_cnt   <= '0;
         box_cnt <= '0;
      end else if (pipe_issue) begin
         if (box_wrap) begin
            box_cnt <= '0;
            if (x_wrap) begin
               x_cnt <= '0;
               y_cnt <= (y_cnt == 10'(V_RES - 1)) ? 10'd0 : y_cnt + 10'd1;
            end else begin
               x_cnt <= x_cnt + 10'd1;
            end
         end else begin
            box_cnt <= box_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      tag_in.valid = pipe_issue;
      tag_in.first = (box_cnt == '0);
      tag_in.last  = box_wrap;
      tag_in.x     = x_cnt;
      tag_in.y     = y_cnt;
      tag_in.box   = box_cnt;
   end

   // Tag shift register mirrors the external pipeline so its tail lines up with pipe_hit.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < PIPE_LAT; i++) tag_pipe[i] <= '0;
      end else if (!stall) begin
         tag_pipe[0] <= tag_in;
         for (int i = 1; i < PIPE_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
      end
   end

   assign tail    = tag_pipe[PIPE_LAT-1];
   assign fold_en = !stall && tail.valid;

   // Strict less-than keeps the earlier (lower) box on equal distances.
   always_comb begin
      fold_hit  = acc_hit;
      fold_dist = acc_dist;
      fold_box  = acc_box;
      if (tail.first) begin
         fold_hit  = pipe_hit;
         fold_dist = pipe_hit ? pipe_dist : '1;
         fold_box  = tail.box;
      end else if (pipe_hit && (!acc_hit || pipe_dist < acc_dist)) begin
         fold_hit  = 1'b1;
         fold_dist = pipe_dist;
         fold_box  = tail.box;
      end
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         acc_hit  <= 1'b0;
         acc_dist <= '0;
         acc_box  <= '0;
      end else if (fold_en) begin
         acc_hit  <= fold_hit;
         acc_dist <= fold_dist;
         acc_box  <= fold_box;
      end
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         pix_valid <= 1'b0;
         pix_x     <= '0;
         pix_y     <= '0;
         pix_hit   <= 1'b0;
         pix_box   <= '0;
         pix_dist  <= '0;
      end else if (fold_en && tail.last) begin
         pix_valid <= 1'b1;
         pix_x     <= tail.x;
         pix_y     <= tail.y;
         pix_hit   <= fold_hit;
         pix_box   <= fold_box;
         pix_dist  <= fold_dist;
      end else if (accept) begin
         pix_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pixel_scan_tracer.sv
// Scoreboard bench: a 4x2/2-box/lat-3 instance and a 4x2/1-box/lat-1 instance, each fed by a
// freezing delay-line model of the ray pipeline with hand-written per-pixel hit tables.
module tb_pixel_scan_tracer;

   localparam logic [48:0] ONES = {49{1'b1}};
   localparam logic [48:0] BIG  = 49'h1_0000_0000_0000;

   logic sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   logic rst_n, rst_nb, start, start_b, a_ready, b_ready;

   logic        a_busy, a_fd, a_stall, a_issue, a_pb, a_phit, a_valid, a_hit, a_box;
   logic [9:0]  a_px, a_py, a_x, a_y;
   logic [48:0] a_pdist, a_dist;
   logic        b_busy, b_fd, b_stall, b_issue, b_pb, b_phit, b_valid, b_hit, b_box;
   logic [9:0]  b_px, b_py, b_x, b_y;
   logic [48:0] b_pdist, b_dist;

   pixel_scan_tracer #(.H_RES(4), .V_RES(2), .NUM_BOXES(2), .PIPE_LAT(3), .DIST_W(49)) dut_a (
      .sysclk(sysclk), .rst_n(rst_n), .start(start), .busy(a_busy), .frame_done(a_fd),
      .pipe_stall(a_stall), .pipe_issue(a_issue), .pipe_pixel_x(a_px), .pipe_pixel_y(a_py),
      .pipe_box_idx(a_pb), .pipe_hit(a_phit), .pipe_dist(a_pdist), .pix_valid(a_valid),
      .pix_ready(a_ready), .pix_x(a_x), .pix_y(a_y), .pix_hit(a_hit), .pix_box(a_box),
      .pix_dist(a_dist));

   pixel_scan_tracer #(.H_RES(4), .V_RES(2), .NUM_BOXES(1), .PIPE_LAT(1), .DIST_W(49)) dut_b (
      .sysclk(sysclk), .rst_n(rst_nb), .start(start_b), .busy(b_busy), .frame_done(b_fd),
      .pipe_stall(b_stall), .pipe_issue(b_issue), .pipe_pixel_x(b_px), .pipe_pixel_y(b_py),
      .pipe_box_idx(b_pb), .pipe_hit(b_phit), .pipe_dist(b_pdist), .pix_valid(b_valid),
      .pix_ready(b_ready), .pix_x(b_x), .pix_y(b_y), .pix_hit(b_hit), .pix_box(b_box),
      .pix_dist(b_dist));

   // Per pixel (index y*4+x), per box: hit flag and distance returned by the pipeline.
   bit          h_tab [0:7][0:1] = '{'{1,1}, '{1,1}, '{0,0}, '{1,0},
                                     '{0,1}, '{1,1}, '{1,1}, '{1,0}};
   logic [48:0] d_tab [0:7][0:1] = '{'{49'd100,49'd40}, '{49'd40,49'd40}, '{49'd3,49'd2},
                                     '{49'd7,49'd1}, '{49'd5,49'd9}, '{49'd5,49'd6},
                                     '{49'd0,49'd1}, '{BIG,49'd0}};
   // Hand-reduced results: two-box instance, and box-0-only instance.
   bit          ea_hit  [0:7] = '{1,1,0,1,1,1,1,1};
   bit          ea_box  [0:7] = '{1,0,0,0,1,0,0,0};
   logic [48:0] ea_dist [0:7] = '{49'd40,49'd40,ONES,49'd7,49'd9,49'd5,49'd0,BIG};
   bit          eb_hit  [0:7] = '{1,1,0,1,0,1,1,1};
   logic [48:0] eb_dist [0:7] = '{49'd100,49'd40,ONES,49'd7,ONES,49'd5,49'd0,BIG};

   int vec_cnt = 0;
   int miss_cnt = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      vec_cnt++;
      if (act !== req) begin
         miss_cnt++;
         $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Pipeline models: PIPE_LAT delay lines that freeze while the DUT stalls.
   logic        ah_dl [0:2];
   logic [48:0] ad_dl [0:2];
   logic        bh_dl;
   logic [48:0] bd_dl;

   always @(posedge sysclk) begin
      if (!a_stall) begin
         ah_dl[0] <= a_issue ? h_tab[(int'(a_py) * 4 + int'(a_px)) % 8][a_pb] : 1'b0;
         ad_dl[0] <= a_issue ? d_tab[(int'(a_py) * 4 + int'(a_px)) % 8][a_pb] : 49'd0;
         for (int i = 1; i < 3; i++) begin
            ah_dl[i] <= ah_dl[i-1];
            ad_dl[i] <= ad_dl[i-1];
         end
      end
      if (!b_stall) begin
         bh_dl <= b_issue ? h_tab[(int'(b_py) * 4 + int'(b_px)) % 8][0] : 1'b0;
         bd_dl <= b_issue ? d_tab[(int'(b_py) * 4 + int'(b_px)) % 8][0] : 49'd0;
      end
   end

   assign a_phit  = ah_dl[2];
   assign a_pdist = ad_dl[2];
   assign b_phit  = bh_dl;
   assign b_pdist = bd_dl;

   int cyc = 0;
   int a_k = 0, a_iss_cnt = 0, a_res_cnt = 0, a_fd_cnt = 0, a_t0 = 0;
   int b_k = 0, b_res_cnt = 0, b_fd_cnt = 0, b_t0 = 0;
   int exp_a [$];
   int exp_b [$];

   always @(negedge sysclk) begin
      int kk, p;
      if (!rst_n) begin
         exp_a.delete();
         a_k = 0;
      end else begin
         if (a_issue) begin
            kk = a_k % 16;
            chk("a_issue_x", a_px, (kk / 2) % 4);
            chk("a_issue_y", a_py, kk / 8);
            chk("a_issue_box", a_pb, kk % 2);
            if (kk == 0) a_t0 = cyc;
            if (kk % 2 == 1) exp_a.push_back(kk / 2);
            a_k++;
            a_iss_cnt++;
         end
         if (a_valid && a_ready) begin
            $display("A pix (%0d,%0d) hit=%0d box=%0d dist=%0h", a_x, a_y, a_hit, a_box, a_dist);
            chk("a_result_expected", exp_a.size() > 0, 1);
            if (exp_a.size() > 0) begin
               p = exp_a.pop_front();
               chk("a_pix_x", a_x, p % 4);
               chk("a_pix_y", a_y, p / 4);
               chk("a_pix_hit", a_hit, ea_hit[p]);
               chk("a_pix_box", a_box, ea_box[p]);
               chk("a_pix_dist", a_dist, ea_dist[p]);
               if (p == 0) chk("a_latency", cyc - a_t0, 5);
            end
            a_res_cnt++;
         end
         if (a_fd) begin
            a_fd_cnt++;
            chk("a_fd_on_last_accept", {a_valid && a_ready, a_x == 10'd3, a_y == 10'd1}, 3'b111);
         end
      end
      if (!rst_nb) begin
         exp_b.delete();
         b_k = 0;
      end else begin
         if (b_issue) begin
            kk = b_k % 8;
            chk("b_issue_xy", {b_py, b_px}, {10'(kk / 4), 10'(kk % 4)});
            chk("b_issue_box", b_pb, 0);
            if (kk == 0) b_t0 = cyc;
            exp_b.push_back(kk);
            b_k++;
         end
         if (b_valid && b_ready) begin
            $display("B pix (%0d,%0d) hit=%0d box=%0d dist=%0h", b_x, b_y, b_hit, b_box, b_dist);
            chk("b_result_expected", exp_b.size() > 0, 1);
            if (exp_b.size() > 0) begin
               p = exp_b.pop_front();
               chk("b_pix_xy", {b_y, b_x}, {10'(p / 4), 10'(p % 4)});
               chk("b_pix_hit", b_hit, eb_hit[p]);
               chk("b_pix_box", b_box, 0);
               chk("b_pix_dist", b_dist, eb_dist[p]);
               if (p == 0) chk("b_latency", cyc - b_t0, 2);
            end
            b_res_cnt++;
         end
         if (b_fd) b_fd_cnt++;
      end
      cyc++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge sysclk);
      #1;
   endtask

   task automatic wait_fd_a(input int snap);
      int n = 0;
      while (a_fd_cnt == snap && n < 400) begin
         tick(1);
         n++;
      end
      chk("a_frame_done_in_time", n < 400, 1);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic check_frame(input string nm, input int sr, input int si, input int sf);
      chk({nm, "_results"}, a_res_cnt - sr, 8);
      chk({nm, "_issues"}, a_iss_cnt - si, 16);
      chk({nm, "_frame_done"}, a_fd_cnt - sf, 1);
      chk({nm, "_busy_after"}, a_busy, 0);
      chk({nm, "_queue_empty"}, exp_a.size(), 0);
   endtask

   int sr, si, sf, sbr, sbf, n;
   logic [9:0]  hx, hy;
   logic [48:0] hd;

   initial begin
      rst_n = 1'b0; rst_nb = 1'b0; start = 1'b0; start_b = 1'b0;
      a_ready = 1'b1; b_ready = 1'b1;
      tick(3);
      chk("rst_a_busy", a_busy, 0);
      chk("rst_a_valid", a_valid, 0);
      chk("rst_a_issue", a_issue, 0);
      chk("rst_a_fd", a_fd, 0);
      chk("rst_a_stall", a_stall, 0);
      chk("rst_a_dist", a_dist, 0);
      chk("rst_a_xyhit", {a_x, a_y, a_hit, a_box}, 0);
      chk("rst_b_busy_valid", {b_busy, b_valid}, 0);
      rst_n = 1'b1; rst_nb = 1'b1;
      tick(2);

      // Clean frame on both instances.
      sr = a_res_cnt; si = a_iss_cnt; sf = a_fd_cnt; sbr = b_res_cnt; sbf = b_fd_cnt;
      start = 1'b1; start_b = 1'b1;
      tick(1);
      start = 1'b0; start_b = 1'b0;
      chk("t1_busy", a_busy, 1);
      wait_fd_a(sf);
      check_frame("t1", sr, si, sf);
      n = 0;
      while (b_fd_cnt == sbf && n < 400) begin tick(1); n++; end
      tick(2);
      chk("t6_results", b_res_cnt - sbr, 8);
      chk("t6_frame_done", b_fd_cnt - sbf, 1);
      chk("t6_busy_after", b_busy, 0);

      // start during SCAN and DRAIN is ignored.
      sr = a_res_cnt; si = a_iss_cnt; sf = a_fd_cnt;
      pulse_start();
      tick(3);
      chk("t4_in_scan", a_issue, 1);
      pulse_start();
      n = 0;
      while (!(a_busy && !a_issue) && n < 100) begin tick(1); n++; end
      chk("t4_reached_drain", n < 100, 1);
      pulse_start();
      wait_fd_a(sf);
      check_frame("t4", sr, si, sf);
      // start held in IDLE right after frame_done restarts.
      sr = a_res_cnt; si = a_iss_cnt; sf = a_fd_cnt;
      start = 1'b1;
      tick(3);
      chk("t4_restart_busy", a_busy, 1);
      start = 1'b0;
      wait_fd_a(sf);
      check_frame("t4r", sr, si, sf);

      // Back-pressure mid-frame.
      sr = a_res_cnt; si = a_iss_cnt; sf = a_fd_cnt;
      pulse_start();
      n = 0;
      while (!(a_res_cnt - sr >= 3 && a_valid) && n < 100) begin tick(1); n++; end
      chk("t3_found_result", n < 100, 1);
      a_ready = 1'b0;
      hx = a_x; hy = a_y; hd = a_dist;
      repeat (5) begin
         @(negedge sysclk);
         chk("t3_stall", a_stall, 1);
         chk("t3_no_issue", a_issue, 0);
         chk("t3_hold_xy", {a_x, a_y}, {hx, hy});
         chk("t3_hold_dist", a_dist, hd);
      end
      tick(1);
      a_ready = 1'b1;
      wait_fd_a(sf);
      check_frame("t3", sr, si, sf);

      // Asynchronous reset mid-frame.
      sr = a_res_cnt;
      pulse_start();
      n = 0;
      while (a_res_cnt - sr < 2 && n < 100) begin tick(1); n++; end
      rst_n = 1'b0;
      #1;
      chk("t5_busy", a_busy, 0);
      chk("t5_valid", a_valid, 0);
      chk("t5_issue", a_issue, 0);
      chk("t5_dist", a_dist, 0);
      tick(2);
      rst_n = 1'b1;
      sf = a_fd_cnt;
      tick(10);
      chk("t5_no_stale_valid", a_valid, 0);
      chk("t5_no_stale_fd", a_fd_cnt - sf, 0);
      sr = a_res_cnt; si = a_iss_cnt; sf = a_fd_cnt;
      pulse_start();
      wait_fd_a(sf);
      check_frame("t5", sr, si, sf);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
